// File: rtl/ps2_kbd_tx_if.sv
// ps2_kbd_tx_if: byte handshake between a scan-code producer and ps2_kbd_tx
//   tx_data  : scan-code byte (master -> slave)
//   tx_valid : tx_data valid (master -> slave)
//   tx_ready : slave accepts a byte on tx_valid & tx_ready (slave -> master)
interface ps2_kbd_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master(output tx_data, tx_valid, input tx_ready);
  modport slave(input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: PS/2 keyboard-side frame transmitter (start, 8 data LSB first, odd parity, stop)
//   clk, reset : system clock, synchronous active-high reset
//   tx         : ps2_kbd_tx_if.slave byte handshake
//   inhibit    : host holding the PS/2 clock low
//   ps2_clk    : PS/2 clock to host, idle high
//   ps2_data   : PS/2 data to host, idle high
//   busy       : frame or inter-frame gap in progress
//   frame_done : one-cycle pulse when a frame's stop bit completes
//   Define PS2_TX_FIFO_EN for a 4-entry byte FIFO instead of a single holding register.
module ps2_kbd_tx #(
  parameter int CLK_DIV  = 1600,
  parameter int GAP_BITS = 2
) (
  input  logic        clk,
  input  logic        reset,
  ps2_kbd_tx_if.slave tx,
  input  logic        inhibit,
  output logic        ps2_clk,
  output logic        ps2_data,
  output logic        busy,
  output logic        frame_done
);
  localparam int GAP_CYC = GAP_BITS * CLK_DIV;
  localparam int CW = $clog2(GAP_CYC > CLK_DIV ? GAP_CYC : CLK_DIV) + 1;
  typedef enum logic [1:0] {IDLE, XMIT, GAP} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [10:0]   frame_q, frame_d;
  logic          ps2_clk_q, ps2_clk_d, ps2_data_q, ps2_data_d, frame_done_q;
  logic          done, abort, accept, pending;
  logic [7:0]    head;
  assign accept = tx.tx_valid & tx.tx_ready;
`ifdef PS2_TX_FIFO_EN
  logic [7:0] fifo_q [4];
  logic [7:0] fifo_d [4];
  logic [1:0] rd_q, rd_d, wr_q, wr_d;
  logic [2:0] occ_q, occ_d;
  assign pending = occ_q != 3'd0;
  assign head = fifo_q[rd_q];
  // the in-flight byte stays in the FIFO until its frame completes
  assign tx.tx_ready = !occ_q[2];
  always_comb begin
    fifo_d = fifo_q;
    if (accept) fifo_d[wr_q] = tx.tx_data;
    wr_d = wr_q + 2'(accept);
    rd_d = rd_q + 2'(done);
    occ_d = occ_q + 3'(accept) - 3'(done);
  end
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
    if (reset) begin
      rd_q <= '0;
      wr_q <= '0;
      occ_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      occ_q <= occ_d;
    end
  end
`else
  logic [7:0] hold_q, hold_d;
  logic       full_q, full_d;
  assign pending = full_q;
  assign head = hold_q;
  assign tx.tx_ready = state_q == IDLE && !full_q;
  always_comb begin
    hold_d = accept ? tx.tx_data : hold_q;
    full_d = accept | (full_q & !done);
  end
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
    full_q <= reset ? 1'b0 : full_d;
  end
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    frame_d = frame_q;
    done = 1'b0;
    // once the stop bit is on the wire the host can no longer abort the frame
    abort = state_q == XMIT && inhibit && bit_q != 4'd10;
    case (state_q)
      IDLE:
        if (pending && !inhibit) begin
          state_d = XMIT;
          cnt_d = '0;
          bit_d = '0;
          frame_d = {1'b1, ~^head, head, 1'b0};
        end
      XMIT:
        if (abort) begin
          state_d = GAP;
          cnt_d = '0;
        end else if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d = '0;
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd10) begin
            state_d = GAP;
            done = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      GAP:
        // the gap restarts while inhibited; the IDLE cycle before the next
        // start bit completes the GAP_CYC idle period on the wire
        if (inhibit) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(GAP_CYC - 2)) begin
          state_d = IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      default: state_d = IDLE;
    endcase
    ps2_clk_d = !(state_q == XMIT && !abort && cnt_q >= CW'(CLK_DIV / 2));
    ps2_data_d = !(state_q == XMIT && !abort) || frame_q[bit_q];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      frame_q <= '1;
      ps2_clk_q <= 1'b1;
      ps2_data_q <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      frame_q <= frame_d;
      ps2_clk_q <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
      frame_done_q <= done;
    end
  end
  assign ps2_clk = ps2_clk_q;
  assign ps2_data = ps2_data_q;
  assign busy = state_q != IDLE;
  assign frame_done = frame_done_q;
endmodule

// File: doc/ps2_kbd_tx.md
PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

Interface
REQ-001 Parameter CLK_DIV, default 1600, clk cycles per PS/2 bit period; even, >=4.
REQ-002 Parameter GAP_BITS, default 2, minimum idle bit periods between frames.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tx_data  input  8  scan-code byte to send.
REQ-006 tx_valid  input  1  tx_data valid; byte accepted on a cycle with tx_valid & tx_ready.
REQ-007 tx_ready  output  1  block can accept a byte this cycle.
REQ-008 inhibit  input  1  host inhibit (host holding PS/2 clock low).
REQ-009 ps2_clk  output  1  PS/2 clock to host, idle high.
REQ-010 ps2_data  output  1  PS/2 data to host, idle high.
REQ-011 busy  output  1  frame or inter-frame gap in progress.
REQ-012 frame_done  output  1  one-cycle pulse after a stop bit completes.

Function
REQ-013 Frame SHALL be 11 bits: start 0, data[0..7] LSB first, odd parity, stop 1.
REQ-014 Each bit SHALL drive ps2_data for exactly CLK_DIV cycles; ps2_clk high for the first CLK_DIV/2, low for the last CLK_DIV/2 (host samples on falling edge).
REQ-015 FSM states SHALL be IDLE, XMIT, GAP; IDLE->XMIT when a byte is pending and inhibit=0; XMIT->GAP after the stop-bit period; GAP->IDLE after GAP_BITS*CLK_DIV cycles.
REQ-016 In IDLE and GAP, ps2_clk=1 and ps2_data=1; busy=1 in XMIT and GAP only.
REQ-017 From IDLE with inhibit=0, ps2_data SHALL go 0 exactly 2 clk cycles after the acceptance edge.
REQ-018 frame_done SHALL pulse on the cycle XMIT->GAP occurs.
REQ-019 Parity SHALL be computed from the byte latched at frame start, not from tx_data.
REQ-020 inhibit=1 in IDLE SHALL hold the pending byte; transmission starts 1 cycle after inhibit falls (GAP rules still apply).
REQ-021 inhibit=1 during XMIT before the parity bit completes SHALL abort: outputs return high next cycle, the same byte is retained, and it is retransmitted in full after inhibit falls and a GAP elapses; no frame_done for the aborted frame.
REQ-022 inhibit=1 during the stop bit SHALL be ignored; frame completes normally.
REQ-023 Bytes SHALL be sent in acceptance order; none lost or duplicated except per REQ-021.
REQ-024 tx_valid while tx_ready=0 SHALL be ignored (no acceptance).

Reset
REQ-025 reset SHALL force IDLE, ps2_clk=1, ps2_data=1, busy=0, frame_done=0, tx_ready=1, clear all pending bytes and counters.
REQ-026 reset asserted mid-frame SHALL take effect next edge and discard the in-flight byte.

Configuration
REQ-027 Macro PS2_TX_FIFO_EN defined: 4-entry FIFO; tx_ready=0 only when 4 bytes pending (in-flight byte counts until frame_done or abort retention ends); acceptance in the cycle frame_done pulses while full SHALL NOT occur.
REQ-028 PS2_TX_FIFO_EN undefined: single holding register; tx_ready=1 only in IDLE with no pending byte; 0 from acceptance until GAP->IDLE.
REQ-029 Frame timing, inhibit handling and reset behaviour SHALL be identical in both builds.

Verification
REQ-030 CLK_DIV=8, GAP_BITS=2, send 0x1C -> ps2_data 0,0,0,1,1,1,0,0,0,0,1 (parity 0), 88-cycle frame, frame_done once, 16-cycle gap.
REQ-031 Send 0x00 -> parity bit 1; send 0xFF -> parity bit 1; send 0x01 -> parity bit 0.
REQ-032 FIFO build: 0xF0,0x1C,0x5A,0x12,0x33 back-to-back -> 4 accepted, tx_ready=0 on fifth until first frame_done, then five frames in order each separated by exactly 16 idle cycles.
REQ-033 inhibit=1 during data bit 3 of 0x5A -> outputs high next cycle, no frame_done; release inhibit -> full 0x5A frame after 16-cycle gap.
REQ-034 inhibit=1 during stop bit -> frame completes, frame_done pulses; next byte waits for inhibit=0.
REQ-035 reset during data bit 5 -> next cycle ps2_clk=1, ps2_data=1, busy=0, tx_ready=1; no frame_done; subsequent byte sent normally.
